seven_segment_capture: RTL and testbench

SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

---
 rtl/seven_segment_pkg.sv | 37 +++
 rtl/seven_segment_glyph_decoder.sv | 39 +++
 rtl/seven_segment_capture.sv | 217 +++++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared types and glyph constants for the seven-segment capture block.
// Glyphs are active-low with bit 6 = segment a down to bit 0 = segment g.
package seven_segment_pkg;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [0:15][6:0] GLYPH_TABLE = {
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic digit_sel_valid(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) ||
               (an == 4'b1011) || (an == 4'b0111);
    endfunction

    function automatic logic [1:0] digit_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        case (an)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seven_segment_glyph_decoder.sv
// Combinational glyph-to-nibble lookup with a legal flag.
// With SEG_CAPTURE_BLANK_EN defined the all-off glyph is legal and flagged as blank.
module seven_segment_glyph_decoder
    import seven_segment_pkg::*;
(
    input  logic [6:0] ca,
`ifdef SEG_CAPTURE_BLANK_EN
    output logic       blank,
`endif
    output logic [3:0] nibble,
    output logic       legal
);

    logic [15:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign hit[gi] = (ca == GLYPH_TABLE[gi]);
        end
    endgenerate

    always_comb begin
        nibble = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) begin
                nibble = 4'(i);
            end
        end
    end

`ifdef SEG_CAPTURE_BLANK_EN
    assign blank = (ca == GLYPH_BLANK);
    assign legal = (|hit) | blank;
`else
    assign legal = |hit;
`endif

endmodule

// File: rtl/seven_segment_capture.sv
// Recovers a 4-digit hex frame by sniffing a multiplexed seven-segment display bus.
// Optional SEG_CAPTURE_BLANK_EN accepts the all-off glyph and reports it on blank_mask.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  an,
    input  logic [6:0]  ca,
    output logic [15:0] frame,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        seg_err,
    output logic        overrun,
    output logic        stalled
`ifdef SEG_CAPTURE_BLANK_EN
    ,
    output logic [3:0]  blank_mask
`endif
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [3:0]    an_s1_q, an_s2_q, an_l_q;
    logic [6:0]    ca_s1_q, ca_s2_q, ca_l_q;
    state_t        state_q, state_d;
    logic [SW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   nib_q, nib_d;
    logic [15:0]   frame_q, frame_d;
    logic          fv_q, fv_d;
    logic          overrun_q, overrun_d;
    logic          seg_err_q, seg_err_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [3:0]    blank_q, blank_d;
    logic [3:0]    bmask_q, bmask_d;

    logic          changed, sel_ok, capture_fire, dec_legal, dec_blank, clear_seen;
    logic [3:0]    dec_nibble;
    logic [1:0]    dig;

    // Two sync stages, then a third copy of the last sample for change detection.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            an_s1_q <= '1;
            an_s2_q <= '1;
            an_l_q  <= '1;
            ca_s1_q <= '1;
            ca_s2_q <= '1;
            ca_l_q  <= '1;
        end else begin
            an_s1_q <= an;
            an_s2_q <= an_s1_q;
            an_l_q  <= an_s2_q;
            ca_s1_q <= ca;
            ca_s2_q <= ca_s1_q;
            ca_l_q  <= ca_s2_q;
        end
    end

    assign changed = (an_s2_q != an_l_q) || (ca_s2_q != ca_l_q);
    assign sel_ok  = digit_sel_valid(an_s2_q);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_WAIT;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_WAIT: begin
                if (sel_ok) begin
                    state_d = ST_SETTLE;
                    count_d = SW'(1);
                end
            end
            ST_SETTLE: begin
                if (!sel_ok) begin
                    state_d = ST_WAIT;
                    count_d = '0;
                end else if (changed) begin
                    count_d = SW'(1);
                end else if (count_q >= SW'(STABLE_CYCLES)) begin
                    state_d = ST_CAPTURE;
                    count_d = '0;
                end else begin
                    count_d = count_q + SW'(1);
                end
            end
            ST_CAPTURE: begin
                if (changed) begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT;
                count_d = '0;
            end
        endcase
    end

    // done_q blocks a second decode while the same glyph stays on the bus.
    always_comb begin
        done_d       = (state_q == ST_CAPTURE) && (state_d == ST_CAPTURE);
        capture_fire = (state_q == ST_CAPTURE) && !done_q;
    end

    // The last-sample copy still holds the stable glyph on the decode cycle.
    assign dig = digit_index(an_l_q);

    seven_segment_glyph_decoder u_decoder (
        .ca     (ca_l_q),
`ifdef SEG_CAPTURE_BLANK_EN
        .blank  (dec_blank),
`endif
        .nibble (dec_nibble),
        .legal  (dec_legal)
    );

`ifndef SEG_CAPTURE_BLANK_EN
    assign dec_blank = 1'b0;
`endif

    always_comb begin
        frame_d    = frame_q;
        fv_d       = fv_q;
        overrun_d  = overrun_q;
        bmask_d    = bmask_q;
        clear_seen = 1'b0;
        // Acceptance wins over loading; the completed frame waits one cycle.
        if (seen_q == 4'hF) begin
            if (!fv_q) begin
                frame_d    = nib_q;
                bmask_d    = blank_q;
                fv_d       = 1'b1;
                clear_seen = 1'b1;
            end else if (frame_ready) begin
                fv_d = 1'b0;
            end else begin
                overrun_d  = 1'b1;
                clear_seen = 1'b1;
            end
        end else if (fv_q && frame_ready) begin
            fv_d = 1'b0;
        end

        seen_d    = clear_seen ? 4'h0 : seen_q;
        nib_d     = nib_q;
        blank_d   = blank_q;
        seg_err_d = 1'b0;
        if (capture_fire) begin
            if (dec_legal) begin
                seen_d[dig]           = 1'b1;
                nib_d[{dig, 2'b00} +: 4] = dec_nibble;
                blank_d[dig]          = dec_blank;
            end else begin
                seg_err_d = 1'b1;
            end
        end

        if (capture_fire) begin
            idle_d = '0;
        end else if (idle_q == TW'(TIMEOUT_CYCLES)) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            seen_q    <= '0;
            nib_q     <= '0;
            frame_q   <= '0;
            fv_q      <= 1'b0;
            overrun_q <= 1'b0;
            seg_err_q <= 1'b0;
            idle_q    <= '0;
            blank_q   <= '0;
            bmask_q   <= '0;
        end else begin
            seen_q    <= seen_d;
            nib_q     <= nib_d;
            frame_q   <= frame_d;
            fv_q      <= fv_d;
            overrun_q <= overrun_d;
            seg_err_q <= seg_err_d;
            idle_q    <= idle_d;
            blank_q   <= blank_d;
            bmask_q   <= bmask_d;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = fv_q;
    assign overrun     = overrun_q;
    assign seg_err     = seg_err_q;
    assign stalled     = (idle_q == TW'(TIMEOUT_CYCLES));
`ifdef SEG_CAPTURE_BLANK_EN
    assign blank_mask  = bmask_q;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench: expected frames are queued as scans are driven and popped on handshake.
module tb_seven_segment_capture;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  an = 4'b1111;
    logic [6:0]  ca = 7'b1111111;
    logic [15:0] frame;
    logic        frame_valid;
    logic        frame_ready = 1'b1;
    logic        seg_err;
    logic        overrun;
    logic        stalled;
`ifdef SEG_CAPTURE_BLANK_EN
    logic [3:0]  blank_mask;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int fv_cycles = 0;
    int seg_cnt   = 0;
    logic [15:0] exp_q[$];
    logic [6:0]  seg_of[16];

    seven_segment_capture #(
        .STABLE_CYCLES  (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .an          (an),
        .ca          (ca),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .seg_err     (seg_err),
        .overrun     (overrun),
`ifdef SEG_CAPTURE_BLANK_EN
        .blank_mask  (blank_mask),
`endif
        .stalled     (stalled)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Handshake monitor: every accepted frame must match the oldest queued expectation.
    always @(negedge clk) begin
        if (clr) begin
            if (frame_valid) fv_cycles++;
            if (seg_err) seg_cnt++;
            if (frame_valid && frame_ready) begin
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("frame_value", 32'(frame), 32'(e));
                    $display("frame accepted %04h (expected %04h)", frame, e);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_digit(input int d, input logic [6:0] g, input int cycles);
        an = 4'b1111 ^ (4'b0001 << d);
        ca = g;
        wait_cycles(cycles);
    endtask

    task automatic idle_bus(input int cycles);
        an = 4'b1111;
        ca = 7'b1111111;
        wait_cycles(cycles);
    endtask

    task automatic scan(input logic [15:0] v, input int hold1);
        drive_digit(0, seg_of[v[3:0]], 20);
        drive_digit(1, seg_of[v[7:4]], hold1);
        drive_digit(2, seg_of[v[11:8]], 20);
        drive_digit(3, seg_of[v[15:12]], 20);
    endtask

    initial begin
        int fv_mark;
        int seg_mark;
        seg_of[0]  = 7'b0000001; seg_of[1]  = 7'b1001111; seg_of[2]  = 7'b0010010;
        seg_of[3]  = 7'b0000110; seg_of[4]  = 7'b1001100; seg_of[5]  = 7'b0100100;
        seg_of[6]  = 7'b0100000; seg_of[7]  = 7'b0001111; seg_of[8]  = 7'b0000000;
        seg_of[9]  = 7'b0000100; seg_of[10] = 7'b0001000; seg_of[11] = 7'b1100000;
        seg_of[12] = 7'b0110001; seg_of[13] = 7'b1000010; seg_of[14] = 7'b0110000;
        seg_of[15] = 7'b0111000;

        // Reset state
        wait_cycles(3);
        @(negedge clk);
        check("rst_frame", 32'(frame), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_seg_err", 32'(seg_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_stalled", 32'(stalled), 32'd0);
        @(posedge clk); #1;
        clr = 1'b1;

        // No digit selected for longer than the timeout
        idle_bus(66);
        @(negedge clk);
        check("stalled_set", 32'(stalled), 32'd1);
        @(posedge clk); #1;

        // Basic scan 0x0006 with the consumer always ready
        fv_cycles = 0;
        seg_cnt   = 0;
        exp_q.push_back(16'h0006);
        drive_digit(0, seg_of[6], 24);
        check("stalled_clear", 32'(stalled), 32'd0);
        drive_digit(1, seg_of[0], 20);
        drive_digit(2, seg_of[0], 20);
        drive_digit(3, seg_of[0], 20);
        idle_bus(8);
        check("basic_valid_cycles", 32'(fv_cycles), 32'd1);
        check("basic_seg_err", 32'(seg_cnt), 32'd0);
        check("basic_drain", 32'(exp_q.size()), 32'd0);

        // Digit 1 too short to be captured, then a proper digit 1
        fv_mark = fv_cycles;
        scan(16'hA5C3, 10);
        idle_bus(8);
        check("short_no_frame", 32'(fv_cycles - fv_mark), 32'd0);
        exp_q.push_back(16'hA5C3);
        drive_digit(1, seg_of[4'hC], 20);
        idle_bus(8);
        check("short_drain", 32'(exp_q.size()), 32'd0);

        // Illegal glyph on digit 2
        fv_mark  = fv_cycles;
        seg_mark = seg_cnt;
        drive_digit(0, seg_of[4'h9], 20);
        drive_digit(1, seg_of[4'hB], 20);
        drive_digit(2, 7'b1111110, 20);
        drive_digit(3, seg_of[4'hD], 20);
        idle_bus(8);
        check("illegal_seg_err_once", 32'(seg_cnt - seg_mark), 32'd1);
        check("illegal_no_frame", 32'(fv_cycles - fv_mark), 32'd0);
        exp_q.push_back(16'hD7B9);
        drive_digit(2, seg_of[4'h7], 20);
        idle_bus(8);
        check("illegal_drain", 32'(exp_q.size()), 32'd0);

        // Consumer stalled across two scans: second frame lost
        frame_ready = 1'b0;
        exp_q.push_back(16'h0010);
        scan(16'h0010, 20);
        idle_bus(4);
        scan(16'h0006, 20);
        idle_bus(8);
        @(negedge clk);
        check("overrun_frame_held", 32'(frame), 32'h0010);
        check("overrun_valid", 32'(frame_valid), 32'd1);
        check("overrun_flag", 32'(overrun), 32'd1);
        @(posedge clk); #1;
        frame_ready = 1'b1;
        idle_bus(6);
        check("overrun_drain", 32'(exp_q.size()), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset mid-frame after two digits
        drive_digit(0, seg_of[4'h5], 20);
        drive_digit(1, seg_of[4'h8], 20);
        idle_bus(4);
        clr = 1'b0;
        @(negedge clk);
        check("midrst_frame", 32'(frame), 32'h0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_valid", 32'(frame_valid), 32'd0);
        @(posedge clk); #1;
        wait_cycles(2);
        clr = 1'b1;
        exp_q.push_back(16'h0002);
        scan(16'h0002, 20);
        idle_bus(8);
        check("midrst_drain", 32'(exp_q.size()), 32'd0);
        check("midrst_overrun_after", 32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
